// File: rtl/div_seq_unit.sv
// ---------------------------------------------------------------------------
// div_seq_unit : iterative restoring divider, signed or unsigned, WIDTH bits.
//
// Serial divide engine that sits beside EX. EX raises start_i and holds it
// until ready_o, and may abort with annul_i. The result is packed as
// {remainder, quotient} for the HI/LO write.
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   When defined, a dividend whose magnitude is below the divisor's (or a
//   zero dividend) completes on the short path with q=0, r=op1_i.
//   The results are the same with or without the macro.
//
// Parameters
//   WIDTH        operand width (>= 4)
//   CNT_W        iteration counter width, 2**CNT_W > WIDTH
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   signed_div_i 1 = two's-complement divide, 0 = unsigned
//   op1_i        dividend (sampled only when a divide is accepted)
//   op2_i        divisor  (sampled only when a divide is accepted)
//   start_i      request, held high until ready_o has been seen
//   annul_i      abort the divide in progress
//   result_o     {remainder, quotient}
//   ready_o      result valid
//   busy_o       engine not idle
//   div_zero_o   current result came from a zero divisor
// ---------------------------------------------------------------------------
module div_seq_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   op1_i,
  input  logic [WIDTH-1:0]   op2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;     // partial remainder
  logic [WIDTH-1:0]   quo_q;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   dvs_q;     // divisor magnitude
  logic               qneg_q;    // quotient needs negation
  logic               rneg_q;    // remainder needs negation
  logic               dz_q;      // short path was taken because of a zero divisor
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;
  logic               busy_q;
  logic               div_zero_q;

  logic               op1_neg_c;
  logic               op2_neg_c;
  logic [WIDTH-1:0]   op1_mag_c;
  logic [WIDTH-1:0]   op2_mag_c;
  logic               early_c;
  logic [WIDTH:0]     shifted_c;
  logic [WIDTH:0]     diff_c;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   quo_fix_c;
  logic [WIDTH-1:0]   rem_fix_c;

  // Operand signs and magnitudes; the most-negative value maps to 2^(WIDTH-1).
  always_comb begin
    op1_neg_c = signed_div_i & op1_i[WIDTH-1];
    op2_neg_c = signed_div_i & op2_i[WIDTH-1];
    op1_mag_c = op1_neg_c ? (~op1_i + WIDTH'(1)) : op1_i;
    op2_mag_c = op2_neg_c ? (~op2_i + WIDTH'(1)) : op2_i;
  end

  // Early-out qualifier (divisor known non-zero where it is used).
  always_comb begin
`ifdef DIV_EARLY_OUT_EN
    early_c = (op1_i == '0) || (op1_mag_c < op2_mag_c);
`else
    early_c = 1'b0;
`endif
  end

  // One restoring step: shift, trial subtract, keep if non-negative.
  // The shifted remainder is below 2*divisor, so WIDTH+1 bits suffice.
  always_comb begin
    shifted_c = {rem_q, quo_q[WIDTH-1]};
    diff_c    = shifted_c - {1'b0, dvs_q};
    if (!diff_c[WIDTH]) begin
      rem_d = diff_c[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted_c[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix; most-negative / -1 wraps naturally to q = 2^(WIDTH-1), r = 0.
  always_comb begin
    quo_fix_c = qneg_q ? (~quo_q + WIDTH'(1)) : quo_q;
    rem_fix_c = rneg_q ? (~rem_q + WIDTH'(1)) : rem_q;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (state_q != S_IDLE && annul_i) begin
      // Abort wins over completion and over the END hold; result is kept.
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            busy_q <= 1'b1;
            if (op2_i == '0) begin
              state_q <= S_DIVZERO;
              dz_q    <= 1'b1;
              rem_q   <= '0;
            end else if (early_c) begin
              // Remainder is the original dividend, quotient zero.
              state_q <= S_DIVZERO;
              dz_q    <= 1'b0;
              rem_q   <= op1_i;
            end else begin
              state_q <= S_ON;
              cnt_q   <= '0;
              rem_q   <= '0;
              quo_q   <= op1_mag_c;
              dvs_q   <= op2_mag_c;
              qneg_q  <= op1_neg_c ^ op2_neg_c;
              rneg_q  <= op1_neg_c;
              dz_q    <= 1'b0;
            end
          end
        end
        S_DIVZERO: begin
          state_q    <= S_END;
          result_q   <= {rem_q, {WIDTH{1'b0}}};
          div_zero_q <= dz_q;
          ready_q    <= 1'b1;
        end
        S_ON: begin
          if (cnt_q == CNT_W'(WIDTH)) begin
            state_q    <= S_END;
            result_q   <= {rem_fix_c, quo_fix_c};
            div_zero_q <= 1'b0;
            ready_q    <= 1'b1;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_END: begin
          if (!start_i) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_div_seq_unit : self-checking bench for div_seq_unit (WIDTH=32).
// Directed cases plus randomized operands against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_div_seq_unit;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          signed_div_i;
  logic [W-1:0]  op1_i;
  logic [W-1:0]  op2_i;
  logic          start_i;
  logic          annul_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;
  logic          busy_o;
  logic          div_zero_o;

  int n_vec = 0;
  int n_err = 0;

  div_seq_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .div_zero_o   (div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division; SV truncates toward zero and the
  // remainder follows the dividend, which is exactly the required rule.
  function automatic logic [63:0] ref_result(input logic sgn, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Edges after E0 until ready_o is seen high.
  function automatic int ref_latency(input logic sgn, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
`ifdef DIV_EARLY_OUT_EN
    longint ma, mb;
`endif
    if (b == '0) return 1;
`ifdef DIV_EARLY_OUT_EN
    ma = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    mb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (ma < mb) return 1;
`endif
    return W + 1;
  endfunction

  // Full transaction from IDLE; inputs are driven 1 time unit after posedge.
  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] exp_r;
    int exp_lat;
    int lat;
    bit seen;
    exp_r   = ref_result(sgn, a, b);
    exp_lat = ref_latency(sgn, a, b);
    signed_div_i = sgn;
    op1_i   = a;
    op2_i   = b;
    start_i = 1'b1;
    @(posedge clk); #1;
    check("busy_e0", 64'(busy_o), 64'(1));
    op1_i = $urandom;
    op2_i = $urandom;
    signed_div_i = 1'($urandom_range(1));
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", result_o, exp_r);
    check("div_zero", 64'(div_zero_o), 64'(b == '0));
    repeat (2) @(posedge clk);
    #1;
    check("hold_result", result_o, exp_r);
    check("hold_ready", 64'(ready_o), 64'(1));
    check("busy_end", 64'(busy_o), 64'(1));
    start_i = 1'b0;
    @(posedge clk); #1;
    check("drop_ready", 64'(ready_o), 64'(0));
    check("drop_div_zero", 64'(div_zero_o), 64'(0));
    check("drop_busy", 64'(busy_o), 64'(0));
    check("keep_result", result_o, exp_r);
  endtask

  initial begin
    bit rdy_seen;
    logic [W-1:0] a, b;
    logic sg;
    rst = 1'b1;
    signed_div_i = 1'b0;
    op1_i = '0;
    op2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result_o, 64'd0);
    check("rst_ready", 64'(ready_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_div_zero", 64'(div_zero_o), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    run_div(1'b0, 32'd100, 32'd7);
    check("u100_7", result_o, {32'd2, 32'd14});
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    check("s_m7_2", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("s_min_m1", result_o, {32'h0, 32'h8000_0000});
    run_div(1'b0, 32'd5, 32'd0);
    run_div(1'b0, 32'd3, 32'd10);
    check("u3_10", result_o, {32'd3, 32'd0});
    run_div(1'b1, 32'd0, 32'hFFFF_FFFD);
    run_div(1'b1, 32'hFFFF_FFFE, 32'd5);

    // Start while annul is high stays idle.
    start_i = 1'b1;
    annul_i = 1'b1;
    op1_i = 32'd50;
    op2_i = 32'd5;
    @(posedge clk); #1;
    check("start_annul_idle", 64'(busy_o), 64'(0));
    start_i = 1'b0;
    annul_i = 1'b0;
    @(posedge clk); #1;

    // Annul mid-divide, then a fresh divide right after.
    rdy_seen = 1'b0;
    signed_div_i = 1'b0;
    op1_i = 32'd1000;
    op2_i = 32'd3;
    start_i = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (ready_o) rdy_seen = 1'b1;
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    if (ready_o) rdy_seen = 1'b1;
    check("annul_busy", 64'(busy_o), 64'(0));
    check("annul_no_ready", 64'(rdy_seen), 64'(0));
    check("annul_keep_result", result_o, ref_result(1'b1, 32'hFFFF_FFFE, 32'd5));
    run_div(1'b0, 32'd9, 32'd3);
    check("u9_3", result_o, {32'd0, 32'd3});

    // Asynchronous reset in the middle of a divide.
    signed_div_i = 1'b0;
    op1_i = 32'h0001_2345;
    op2_i = 32'd7;
    start_i = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_result", result_o, 64'd0);
    check("arst_busy", 64'(busy_o), 64'(0));
    check("arst_ready", 64'(ready_o), 64'(0));
    check("arst_div_zero", 64'(div_zero_o), 64'(0));
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_div(1'b0, 32'd6, 32'd4);
    check("u6_4", result_o, {32'd2, 32'd1});

    // Randomized operands.
    for (int k = 0; k < 40; k++) begin
      sg = 1'($urandom_range(1));
      a  = $urandom;
      case ($urandom_range(4))
        0: b = '0;
        1: b = 32'($urandom_range(15));
        2: b = a + 32'($urandom_range(3));
        default: b = $urandom >> $urandom_range(31);
      endcase
      if (k == 7) begin
        sg = 1'b1;
        a  = 32'h8000_0000;
        b  = 32'hFFFF_FFFF;
      end
      run_div(sg, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
